// File: rtl/riscv_ooo_pkg.sv
// Shared widths and encodings for the out-of-order core's scheduling logic.
package riscv_ooo_pkg;

    // Physical register tag width and number of functional units fed by the issue queue
    localparam int TAG_W    = 6;
    localparam int NUM_FU   = 3;

    // Datapath and bookkeeping field widths
    localparam int DATA_W   = 32;
    localparam int ALU_OP_W = 4;
    localparam int ROB_W    = 5;
    localparam int FU_SEL_W = 2;

    // ALU operation encodings carried through the queue untouched
    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    // Functional unit index encodings used on disp_fu_sel
    typedef enum logic [FU_SEL_W-1:0] {
        FU_ALU0 = 2'd0,
        FU_ALU1 = 2'd1,
        FU_ALU2 = 2'd2
    } fu_idx_e;

endpackage

// File: rtl/iq_select.sv
// Fixed-priority picker: grants the lowest-index asserted request.
module iq_select #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_req,
    output logic [N-1:0] o_grant,
    output logic         o_valid
);

    logic w_taken;

    // Walk from index 0 upward and grant the first request seen
    always_comb begin
        o_grant = '0;
        w_taken = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i_req[i] && !w_taken) begin
                o_grant[i] = 1'b1;
                w_taken    = 1'b1;
            end
        end
    end

    assign o_valid = |i_req;

endmodule

// File: rtl/issue_queue.sv
// Unified issue queue: holds dispatched ops until both operands are ready,
// snoops the result buses for wakeup, and issues at most one op per FU per
// cycle (lowest index first). The count port is 4 bits, so DEPTH <= 15.
module issue_queue #(
    parameter int DEPTH  = 8,
    parameter int NUM_FU = riscv_ooo_pkg::NUM_FU,
    parameter int TAG_W  = riscv_ooo_pkg::TAG_W
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          disp_valid,
    output logic                                          disp_ready,
    input  logic [TAG_W-1:0]                              disp_src1_tag,
    input  logic [TAG_W-1:0]                              disp_src2_tag,
    input  logic                                          disp_src1_rdy,
    input  logic                                          disp_src2_rdy,
    input  logic [riscv_ooo_pkg::DATA_W-1:0]              disp_src1_val,
    input  logic [riscv_ooo_pkg::DATA_W-1:0]              disp_src2_val,
    input  logic [riscv_ooo_pkg::ALU_OP_W-1:0]            disp_alu_op,
    input  logic [riscv_ooo_pkg::FU_SEL_W-1:0]            disp_fu_sel,
    input  logic [TAG_W-1:0]                              disp_dest_tag,
    input  logic [riscv_ooo_pkg::ROB_W-1:0]               disp_rob_idx,
    input  logic [NUM_FU-1:0]                             wb_valid,
    input  logic [NUM_FU-1:0][TAG_W-1:0]                  wb_tag,
    input  logic [NUM_FU-1:0][riscv_ooo_pkg::DATA_W-1:0]  wb_data,
    input  logic [NUM_FU-1:0]                             fu_ready,
    output logic [NUM_FU-1:0]                             iss_valid,
    output logic [NUM_FU-1:0][riscv_ooo_pkg::DATA_W-1:0]  iss_src1,
    output logic [NUM_FU-1:0][riscv_ooo_pkg::DATA_W-1:0]  iss_src2,
    output logic [NUM_FU-1:0][riscv_ooo_pkg::ALU_OP_W-1:0] iss_alu_op,
    output logic [NUM_FU-1:0][TAG_W-1:0]                  iss_dest_tag,
    output logic [NUM_FU-1:0][riscv_ooo_pkg::ROB_W-1:0]   iss_rob_idx,
    input  logic                                          flush,
    output logic [3:0]                                    count
);

    localparam int DW = riscv_ooo_pkg::DATA_W;
    localparam int OW = riscv_ooo_pkg::ALU_OP_W;
    localparam int RW = riscv_ooo_pkg::ROB_W;
    localparam int SW = riscv_ooo_pkg::FU_SEL_W;
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    // Entry state
    logic [DEPTH-1:0]   r_valid;
    logic [DEPTH-1:0]   r_src1_rdy;
    logic [DEPTH-1:0]   r_src2_rdy;
    logic [TAG_W-1:0]   r_src1_tag [DEPTH];
    logic [TAG_W-1:0]   r_src2_tag [DEPTH];
    logic [DW-1:0]      r_src1_val [DEPTH];
    logic [DW-1:0]      r_src2_val [DEPTH];
    logic [OW-1:0]      r_alu_op   [DEPTH];
    logic [SW-1:0]      r_fu_sel   [DEPTH];
    logic [TAG_W-1:0]   r_dest_tag [DEPTH];
    logic [RW-1:0]      r_rob_idx  [DEPTH];
    logic [3:0]         r_count;

    // Issue port registers
    logic [NUM_FU-1:0]           r_iss_valid;
    logic [NUM_FU-1:0][DW-1:0]   r_iss_src1;
    logic [NUM_FU-1:0][DW-1:0]   r_iss_src2;
    logic [NUM_FU-1:0][OW-1:0]   r_iss_alu_op;
    logic [NUM_FU-1:0][TAG_W-1:0] r_iss_dest_tag;
    logic [NUM_FU-1:0][RW-1:0]   r_iss_rob_idx;

    // Wakeup and dispatch-bypass matches
    logic [DEPTH-1:0]   w_wake1;
    logic [DEPTH-1:0]   w_wake2;
    logic [DW-1:0]      w_wake1_data [DEPTH];
    logic [DW-1:0]      w_wake2_data [DEPTH];
    logic               w_byp1;
    logic               w_byp2;
    logic [DW-1:0]      w_byp1_data;
    logic [DW-1:0]      w_byp2_data;

    // Allocation and selection
    logic [DEPTH-1:0]   w_free;
    logic [DEPTH-1:0]   w_alloc_grant;
    logic               w_alloc_valid;
    logic               w_disp_fire;
    logic [NUM_FU-1:0][DEPTH-1:0] w_elig;
    logic [NUM_FU-1:0][DEPTH-1:0] w_req;
    logic [NUM_FU-1:0][DEPTH-1:0] w_grant;
    logic [NUM_FU-1:0]            w_gvalid;
    logic [DEPTH-1:0]             w_issue_mask;
    logic [3:0]                   w_issue_cnt;
    logic [NUM_FU-1:0][DW-1:0]    w_sel_src1;
    logic [NUM_FU-1:0][DW-1:0]    w_sel_src2;
    logic [NUM_FU-1:0][OW-1:0]    w_sel_alu_op;
    logic [NUM_FU-1:0][TAG_W-1:0] w_sel_dest_tag;
    logic [NUM_FU-1:0][RW-1:0]    w_sel_rob_idx;

    // Full when every slot is counted; a slot freed by issue this cycle is
    // not reusable until the next one, so this looks only at registered count
    assign disp_ready  = (r_count < DEPTH_C);
    assign count       = r_count;
    assign w_free      = ~r_valid;
    assign w_disp_fire = disp_valid && disp_ready && w_alloc_valid && !flush;

    iq_select #(.N(DEPTH)) u_alloc (
        .i_req   (w_free),
        .o_grant (w_alloc_grant),
        .o_valid (w_alloc_valid)
    );

    // Per-FU eligibility and lowest-index pick; fu_ready low masks the requests
    genvar gi, gk;
    generate
        for (gk = 0; gk < NUM_FU; gk++) begin : g_fu
            localparam logic [SW-1:0] FU_ID = SW'(gk);
            for (gi = 0; gi < DEPTH; gi++) begin : g_ent
                assign w_elig[gk][gi] = r_valid[gi] && r_src1_rdy[gi] &&
                                        r_src2_rdy[gi] && (r_fu_sel[gi] == FU_ID);
            end
            assign w_req[gk] = fu_ready[gk] ? w_elig[gk] : '0;

            iq_select #(.N(DEPTH)) u_sel (
                .i_req   (w_req[gk]),
                .o_grant (w_grant[gk]),
                .o_valid (w_gvalid[gk])
            );
        end
    endgenerate

    // Result-bus tag match for every stored source; tag 0 never wakes
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_wake1[i]      = 1'b0;
            w_wake2[i]      = 1'b0;
            w_wake1_data[i] = '0;
            w_wake2_data[i] = '0;
            for (int j = 0; j < NUM_FU; j++) begin
                if (wb_valid[j] && (wb_tag[j] != '0)) begin
                    if (wb_tag[j] == r_src1_tag[i]) begin
                        w_wake1[i]      = 1'b1;
                        w_wake1_data[i] = wb_data[j];
                    end
                    if (wb_tag[j] == r_src2_tag[i]) begin
                        w_wake2[i]      = 1'b1;
                        w_wake2_data[i] = wb_data[j];
                    end
                end
            end
        end
    end

    // Same-cycle result match for the op being dispatched
    always_comb begin
        w_byp1      = 1'b0;
        w_byp2      = 1'b0;
        w_byp1_data = '0;
        w_byp2_data = '0;
        for (int j = 0; j < NUM_FU; j++) begin
            if (wb_valid[j] && (wb_tag[j] != '0)) begin
                if (wb_tag[j] == disp_src1_tag) begin
                    w_byp1      = 1'b1;
                    w_byp1_data = wb_data[j];
                end
                if (wb_tag[j] == disp_src2_tag) begin
                    w_byp2      = 1'b1;
                    w_byp2_data = wb_data[j];
                end
            end
        end
    end

    // Gather the granted entry's payload per FU and tally this cycle's issues
    always_comb begin
        w_issue_mask   = '0;
        w_issue_cnt    = '0;
        w_sel_src1     = '0;
        w_sel_src2     = '0;
        w_sel_alu_op   = '0;
        w_sel_dest_tag = '0;
        w_sel_rob_idx  = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            w_issue_mask = w_issue_mask | w_grant[k];
            w_issue_cnt  = w_issue_cnt + {3'b000, w_gvalid[k]};
            for (int i = 0; i < DEPTH; i++) begin
                if (w_grant[k][i]) begin
                    w_sel_src1[k]     = r_src1_val[i];
                    w_sel_src2[k]     = r_src2_val[i];
                    w_sel_alu_op[k]   = r_alu_op[i];
                    w_sel_dest_tag[k] = r_dest_tag[i];
                    w_sel_rob_idx[k]  = r_rob_idx[i];
                end
            end
        end
    end

    // Valid bits: free issued slots, claim the allocated slot on dispatch
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_valid <= '0;
        end else begin
            r_valid <= (r_valid & ~w_issue_mask) | (w_disp_fire ? w_alloc_grant : '0);
        end
    end

    // Entry payload and operand readiness: write on dispatch, capture on wakeup
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_disp_fire && w_alloc_grant[i]) begin
                r_src1_tag[i] <= disp_src1_tag;
                r_src2_tag[i] <= disp_src2_tag;
                r_src1_rdy[i] <= disp_src1_rdy || w_byp1;
                r_src2_rdy[i] <= disp_src2_rdy || w_byp2;
                r_src1_val[i] <= (!disp_src1_rdy && w_byp1) ? w_byp1_data : disp_src1_val;
                r_src2_val[i] <= (!disp_src2_rdy && w_byp2) ? w_byp2_data : disp_src2_val;
                r_alu_op[i]   <= disp_alu_op;
                r_fu_sel[i]   <= disp_fu_sel;
                r_dest_tag[i] <= disp_dest_tag;
                r_rob_idx[i]  <= disp_rob_idx;
            end else if (r_valid[i]) begin
                if (!r_src1_rdy[i] && w_wake1[i]) begin
                    r_src1_rdy[i] <= 1'b1;
                    r_src1_val[i] <= w_wake1_data[i];
                end
                if (!r_src2_rdy[i] && w_wake2[i]) begin
                    r_src2_rdy[i] <= 1'b1;
                    r_src2_val[i] <= w_wake2_data[i];
                end
            end
        end
    end

    // Issue registers and occupancy counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_iss_valid    <= '0;
            r_iss_src1     <= '0;
            r_iss_src2     <= '0;
            r_iss_alu_op   <= '0;
            r_iss_dest_tag <= '0;
            r_iss_rob_idx  <= '0;
            r_count        <= '0;
        end else if (flush) begin
            r_iss_valid <= '0;
            r_count     <= '0;
        end else begin
            r_iss_valid <= w_gvalid;
            r_count     <= r_count + {3'b000, w_disp_fire} - w_issue_cnt;
            for (int k = 0; k < NUM_FU; k++) begin
                if (w_gvalid[k]) begin
                    r_iss_src1[k]     <= w_sel_src1[k];
                    r_iss_src2[k]     <= w_sel_src2[k];
                    r_iss_alu_op[k]   <= w_sel_alu_op[k];
                    r_iss_dest_tag[k] <= w_sel_dest_tag[k];
                    r_iss_rob_idx[k]  <= w_sel_rob_idx[k];
                end
            end
        end
    end

    assign iss_valid    = r_iss_valid;
    assign iss_src1     = r_iss_src1;
    assign iss_src2     = r_iss_src2;
    assign iss_alu_op   = r_iss_alu_op;
    assign iss_dest_tag = r_iss_dest_tag;
    assign iss_rob_idx  = r_iss_rob_idx;

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: dispatch, wakeup, bypass, per-FU issue,
// full-queue backpressure, flush and mid-operation reset.
module tb_issue_queue;

    localparam int DEPTH  = 8;
    localparam int NUM_FU = 3;
    localparam int TAG_W  = 6;

    logic                          clk;
    logic                          rst;
    logic                          disp_valid;
    logic                          disp_ready;
    logic [TAG_W-1:0]              disp_src1_tag;
    logic [TAG_W-1:0]              disp_src2_tag;
    logic                          disp_src1_rdy;
    logic                          disp_src2_rdy;
    logic [31:0]                   disp_src1_val;
    logic [31:0]                   disp_src2_val;
    logic [3:0]                    disp_alu_op;
    logic [1:0]                    disp_fu_sel;
    logic [TAG_W-1:0]              disp_dest_tag;
    logic [4:0]                    disp_rob_idx;
    logic [NUM_FU-1:0]             wb_valid;
    logic [NUM_FU-1:0][TAG_W-1:0]  wb_tag;
    logic [NUM_FU-1:0][31:0]       wb_data;
    logic [NUM_FU-1:0]             fu_ready;
    logic [NUM_FU-1:0]             iss_valid;
    logic [NUM_FU-1:0][31:0]       iss_src1;
    logic [NUM_FU-1:0][31:0]       iss_src2;
    logic [NUM_FU-1:0][3:0]        iss_alu_op;
    logic [NUM_FU-1:0][TAG_W-1:0]  iss_dest_tag;
    logic [NUM_FU-1:0][4:0]        iss_rob_idx;
    logic                          flush;
    logic [3:0]                    count;

    int n_tests = 0;
    int n_fail  = 0;

    issue_queue #(.DEPTH(DEPTH), .NUM_FU(NUM_FU), .TAG_W(TAG_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .disp_valid    (disp_valid),
        .disp_ready    (disp_ready),
        .disp_src1_tag (disp_src1_tag),
        .disp_src2_tag (disp_src2_tag),
        .disp_src1_rdy (disp_src1_rdy),
        .disp_src2_rdy (disp_src2_rdy),
        .disp_src1_val (disp_src1_val),
        .disp_src2_val (disp_src2_val),
        .disp_alu_op   (disp_alu_op),
        .disp_fu_sel   (disp_fu_sel),
        .disp_dest_tag (disp_dest_tag),
        .disp_rob_idx  (disp_rob_idx),
        .wb_valid      (wb_valid),
        .wb_tag        (wb_tag),
        .wb_data       (wb_data),
        .fu_ready      (fu_ready),
        .iss_valid     (iss_valid),
        .iss_src1      (iss_src1),
        .iss_src2      (iss_src2),
        .iss_alu_op    (iss_alu_op),
        .iss_dest_tag  (iss_dest_tag),
        .iss_rob_idx   (iss_rob_idx),
        .flush         (flush),
        .count         (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    // Present a dispatch request; caller advances the clock and drops disp_valid
    task automatic drive_disp(input logic [5:0] t1, input logic r1, input logic [31:0] v1,
                              input logic [5:0] t2, input logic r2, input logic [31:0] v2,
                              input logic [1:0] sel, input logic [4:0] rob);
        disp_valid    = 1'b1;
        disp_src1_tag = t1;
        disp_src1_rdy = r1;
        disp_src1_val = v1;
        disp_src2_tag = t2;
        disp_src2_rdy = r2;
        disp_src2_val = v2;
        disp_alu_op   = 4'd0;
        disp_fu_sel   = sel;
        disp_dest_tag = {1'b0, rob};
        disp_rob_idx  = rob;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; disp_valid = 1'b0;
        disp_src1_tag = '0; disp_src2_tag = '0; disp_src1_rdy = 1'b0; disp_src2_rdy = 1'b0;
        disp_src1_val = '0; disp_src2_val = '0; disp_alu_op = '0; disp_fu_sel = '0;
        disp_dest_tag = '0; disp_rob_idx = '0;
        wb_valid = '0; wb_tag = '0; wb_data = '0; fu_ready = '0;

        // Reset state
        step(); step();
        check_eq("rst_count",     32'(count), 32'd0);
        check_eq("rst_iss_valid", 32'(iss_valid), 32'd0);
        check_eq("rst_disp_ready", 32'(disp_ready), 32'd1);
        check_eq("rst_iss_src1",  iss_src1[0], 32'd0);
        rst = 1'b0;
        step();

        // ADD 5 + 7 on FU0: dispatch edge, then issue on the next edge
        fu_ready = 3'b111;
        drive_disp(6'd0, 1'b1, 32'd5, 6'd0, 1'b1, 32'd7, 2'd0, 5'd1);
        step();
        disp_valid = 1'b0;
        check_eq("add_count_after_disp", 32'(count), 32'd1);
        check_eq("add_no_issue_yet",     32'(iss_valid), 32'd0);
        step();
        check_eq("add_iss_valid", 32'(iss_valid), 32'h1);
        check_eq("add_iss_src1",  iss_src1[0], 32'd5);
        check_eq("add_iss_src2",  iss_src2[0], 32'd7);
        check_eq("add_iss_rob",   32'(iss_rob_idx[0]), 32'd1);
        check_eq("add_count_zero", 32'(count), 32'd0);
        step();
        check_eq("add_pulse_one_cycle", 32'(iss_valid), 32'd0);

        // Wakeup: src1 tag 12 woken by FU1 result two cycles after dispatch
        drive_disp(6'd12, 1'b0, 32'd0, 6'd0, 1'b1, 32'd3, 2'd1, 5'd2);
        step();
        disp_valid = 1'b0;
        step();
        check_eq("wake_wait", 32'(iss_valid), 32'd0);
        wb_valid = 3'b010; wb_tag[1] = 6'd12; wb_data[1] = 32'hDEAD;
        step();
        wb_valid = '0;
        check_eq("wake_edge_no_issue", 32'(iss_valid), 32'd0);
        step();
        check_eq("wake_iss_valid", 32'(iss_valid), 32'h2);
        check_eq("wake_iss_src1",  iss_src1[1], 32'hDEAD);
        check_eq("wake_iss_src2",  iss_src2[1], 32'd3);
        check_eq("wake_count",     32'(count), 32'd0);

        // Fill all 8 slots for FU2 while it is stalled
        fu_ready = 3'b011;
        for (int i = 0; i < DEPTH; i++) begin
            drive_disp(6'd0, 1'b1, 32'(100 + i), 6'd0, 1'b1, 32'(i), 2'd2, 5'(i));
            step();
        end
        disp_valid = 1'b0;
        check_eq("full_count", 32'(count), 32'd8);
        check_eq("full_disp_ready", 32'(disp_ready), 32'd0);
        // Release FU2 while offering a dispatch: the freed slot is not reused this cycle
        drive_disp(6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd1, 2'd0, 5'd31);
        fu_ready = 3'b111;
        step();
        disp_valid = 1'b0;
        check_eq("full_first_count", 32'(count), 32'd7);
        check_eq("full_first_valid", 32'(iss_valid), 32'h4);
        check_eq("full_first_rob",   32'(iss_rob_idx[2]), 32'd0);
        for (int i = 1; i < DEPTH; i++) begin
            step();
            check_eq($sformatf("drain_valid_%0d", i), 32'(iss_valid), 32'h4);
            check_eq($sformatf("drain_rob_%0d", i),   32'(iss_rob_idx[2]), 32'(i));
            check_eq($sformatf("drain_src1_%0d", i),  iss_src1[2], 32'(100 + i));
        end
        check_eq("drain_count", 32'(count), 32'd0);
        step();
        check_eq("drain_idle", 32'(iss_valid), 32'd0);

        // Three ready entries, one per FU, issue together
        fu_ready = 3'b000;
        for (int k = 0; k < NUM_FU; k++) begin
            drive_disp(6'd0, 1'b1, 32'(10 + k), 6'd0, 1'b1, 32'd0, 2'(k), 5'(10 + k));
            step();
        end
        disp_valid = 1'b0;
        check_eq("tri_count_before", 32'(count), 32'd3);
        check_eq("tri_stalled",      32'(iss_valid), 32'd0);
        fu_ready = 3'b111;
        step();
        check_eq("tri_iss_valid", 32'(iss_valid), 32'h7);
        check_eq("tri_count_after", 32'(count), 32'd0);
        for (int k = 0; k < NUM_FU; k++) begin
            check_eq($sformatf("tri_src1_fu%0d", k), iss_src1[k], 32'(10 + k));
        end

        // Dispatch bypass: src2 tag 9 matches a result on the same cycle
        drive_disp(6'd0, 1'b1, 32'd1, 6'd9, 1'b0, 32'd0, 2'd0, 5'd20);
        wb_valid = 3'b100; wb_tag[2] = 6'd9; wb_data[2] = 32'd42;
        step();
        disp_valid = 1'b0;
        wb_valid = '0;
        check_eq("byp_count", 32'(count), 32'd1);
        step();
        check_eq("byp_iss_valid", 32'(iss_valid), 32'h1);
        check_eq("byp_iss_src2",  iss_src2[0], 32'd42);

        // Four waiting entries; a tag-0 result must wake nothing
        drive_disp(6'd20, 1'b0, 32'd0, 6'd0, 1'b1, 32'd0, 2'd0, 5'd3);
        step();
        drive_disp(6'd21, 1'b0, 32'd0, 6'd0, 1'b1, 32'd0, 2'd1, 5'd4);
        step();
        drive_disp(6'd22, 1'b0, 32'd0, 6'd0, 1'b1, 32'd0, 2'd2, 5'd5);
        step();
        drive_disp(6'd0, 1'b0, 32'd0, 6'd0, 1'b1, 32'd0, 2'd0, 5'd6);
        step();
        disp_valid = 1'b0;
        wb_valid = 3'b001; wb_tag[0] = 6'd0; wb_data[0] = 32'd77;
        step();
        wb_valid = '0;
        check_eq("tag0_no_issue_a", 32'(iss_valid), 32'd0);
        step();
        check_eq("tag0_no_issue_b", 32'(iss_valid), 32'd0);
        check_eq("flush_pre_count", 32'(count), 32'd4);

        // Flush with a simultaneous dispatch: everything dropped
        flush = 1'b1;
        drive_disp(6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd1, 2'd1, 5'd9);
        step();
        flush = 1'b0;
        disp_valid = 1'b0;
        check_eq("flush_count",      32'(count), 32'd0);
        check_eq("flush_iss_valid",  32'(iss_valid), 32'd0);
        check_eq("flush_disp_ready", 32'(disp_ready), 32'd1);
        step();
        check_eq("flush_after_valid", 32'(iss_valid), 32'd0);
        check_eq("flush_after_count", 32'(count), 32'd0);

        // Reset arriving together with a wakeup overrides it
        drive_disp(6'd30, 1'b0, 32'd0, 6'd0, 1'b1, 32'd5, 2'd1, 5'd11);
        step();
        disp_valid = 1'b0;
        wb_valid = 3'b001; wb_tag[0] = 6'd30; wb_data[0] = 32'h1234;
        rst = 1'b1;
        step();
        rst = 1'b0;
        wb_valid = '0;
        check_eq("mrst_count",      32'(count), 32'd0);
        check_eq("mrst_iss_valid",  32'(iss_valid), 32'd0);
        check_eq("mrst_iss_src1_1", iss_src1[1], 32'd0);
        check_eq("mrst_iss_src2_0", iss_src2[0], 32'd0);
        check_eq("mrst_iss_rob_2",  32'(iss_rob_idx[2]), 32'd0);
        check_eq("mrst_dest_2",     32'(iss_dest_tag[2]), 32'd0);
        check_eq("mrst_disp_ready", 32'(disp_ready), 32'd1);
        step();
        check_eq("mrst_no_late_issue", 32'(iss_valid), 32'd0);
        check_eq("mrst_count_after",   32'(count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of queue entries.
REQ-002 SHALL have parameter NUM_FU, default 3, number of functional units fed.
REQ-003 SHALL have parameter TAG_W, default 6, physical-register tag width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port disp_valid  input  1  dispatch request.
REQ-007 SHALL have port disp_ready  output  1  queue can accept a dispatch.
REQ-008 SHALL have port disp_src1_tag, disp_src2_tag  input  TAG_W each  source tags.
REQ-009 SHALL have port disp_src1_rdy, disp_src2_rdy  input  1 each  operand already valid; set src2_rdy for immediates.
REQ-010 SHALL have port disp_src1_val, disp_src2_val  input  32 each  operand or immediate value.
REQ-011 SHALL have port disp_alu_op  input  4  ALU operation code.
REQ-012 SHALL have port disp_fu_sel  input  2  target FU index, 0..NUM_FU-1.
REQ-013 SHALL have port disp_dest_tag  input  TAG_W  destination tag.
REQ-014 SHALL have port disp_rob_idx  input  5  ROB index.
REQ-015 SHALL have port wb_valid  input  NUM_FU  result-bus valid per FU.
REQ-016 SHALL have port wb_tag  input  NUM_FU x TAG_W  result tags.
REQ-017 SHALL have port wb_data  input  NUM_FU x 32  result values.
REQ-018 SHALL have port fu_ready  input  NUM_FU  FU k accepts an issue this cycle.
REQ-019 SHALL have port iss_valid  output  NUM_FU  issue pulse per FU.
REQ-020 SHALL have ports iss_src1, iss_src2 (NUM_FU x 32), iss_alu_op (NUM_FU x 4), iss_dest_tag (NUM_FU x TAG_W), iss_rob_idx (NUM_FU x 5)  output  per-FU issue payload.
REQ-021 SHALL have port flush  input  1  discard all entries.
REQ-022 SHALL have port count  output  4  occupied entries.

Function
REQ-023 disp_ready SHALL equal (count < DEPTH), combinational from registered state.
REQ-024 Dispatch SHALL occur when disp_valid && disp_ready; entry written into lowest-index free slot at the clock edge.
REQ-025 Each cycle, for every valid entry source not ready, if any wb_valid[j] with wb_tag[j] == source tag, entry SHALL set ready and capture wb_data[j] at the edge.
REQ-026 Dispatch bypass: a dispatched source not ready whose tag matches a same-cycle wb SHALL be stored ready with wb_data.
REQ-027 Entry SHALL be eligible for FU k when valid, both sources ready (registered), and fu_sel == k.
REQ-028 For each k with fu_ready[k], SHALL select lowest-index eligible entry; at most one issue per FU per cycle.
REQ-029 Selected entry SHALL be freed and its payload registered to iss_* for FU k; iss_valid[k] high exactly one cycle (latency 1 from selection).
REQ-030 fu_ready[k] low SHALL suppress selection for FU k; iss_valid[k] low next cycle.
REQ-031 Earliest issue: entry dispatched with both sources ready at edge N SHALL issue at edge N+1; entry woken at edge N SHALL issue at edge N+1.
REQ-032 Simultaneous dispatch and issue when full: disp_ready stays low (no same-cycle slot reuse).
REQ-033 count SHALL update by +dispatch minus number of issues each cycle.
REQ-034 flush SHALL clear all valid bits and iss_valid at the edge; dispatch in flush cycle ignored.
REQ-035 wb with tag 0 SHALL wake nothing (tag 0 is hardwired x0, always dispatched ready).

Reset
REQ-036 rst SHALL clear all entry valid bits, count = 0, iss_valid = 0, all iss_* payload = 0; disp_ready = 1 the cycle after.
REQ-037 rst mid-operation SHALL override dispatch, wakeup and issue in that cycle.

Structure
REQ-038 TAG_W, NUM_FU, ALU op codes and FU index encodings SHALL live in shared package riscv_ooo_pkg.
REQ-039 Lowest-index selection SHALL be sub-module iq_select (DEPTH-bit request vector in, one-hot grant + valid out), instantiated once per FU and once for free-slot allocation.

Verification
REQ-040 Reset, dispatch ADD (op 0) src1=5 src2=7 ready, fu_sel=0, fu_ready=1 -> iss_valid[0] one cycle later, iss_src1=5, iss_src2=7, count returns 0.
REQ-041 Dispatch src1_tag=12 not ready; wb_valid[1], wb_tag=12, wb_data=0xDEAD two cycles later -> issue next cycle with iss_src1=0xDEAD.
REQ-042 Dispatch 8 entries fu_sel=2, fu_ready=0 -> disp_ready=0, count=8; raise fu_ready[2] -> one issue per cycle, index order 0..7.
REQ-043 Three ready entries fu_sel 0,1,2 -> all three iss_valid bits high same cycle; count drops by 3.
REQ-044 Dispatch src2_tag=9 coincident with wb_tag=9 data=42 -> entry issues next cycle with iss_src2=42.
REQ-045 Queue holding 4 entries, assert flush -> count=0, no iss_valid next cycle; assert rst mid-wakeup -> all outputs at reset values.
